// File: rtl/alert_handler_pkg.sv
// Shared types and default widths for the alert handler escalation path.
package alert_handler_pkg;

   localparam int AccuCntDwDef = 16;
   localparam int EscCntDwDef  = 32;
   localparam int NEscSevDef   = 4;
   localparam int N_PHASES     = 4;
   localparam int PHASE_DW     = 2;

   // Bit 2 marks an active escalation phase; bits [1:0] then carry the phase index.
   typedef enum logic [2:0] {
      Idle     = 3'b000,
      Timeout  = 3'b001,
      Terminal = 3'b011,
      Phase0   = 3'b100,
      Phase1   = 3'b101,
      Phase2   = 3'b110,
      Phase3   = 3'b111
   } cls_state_e;

endpackage

// File: rtl/alert_handler_accu.sv
// Saturating per-class alert accumulator with threshold hit and overflow flag.
module alert_handler_accu
   import alert_handler_pkg::*;
#(
   parameter int AccuCntDw = AccuCntDwDef
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 clr_i,
   input  logic                 trig_i,
   input  logic [AccuCntDw-1:0] thresh_i,
   output logic [AccuCntDw-1:0] cnt_o,
   output logic                 hit_o,
   output logic                 fail_o
);

   logic [AccuCntDw-1:0] cnt_q;
   logic                 sat;

   assign sat = &cnt_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (trig_i && !sat) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // Threshold is checked against the count before this alert is added.
   assign hit_o  = trig_i & (cnt_q >= thresh_i);
   assign fail_o = trig_i & sat;
   assign cnt_o  = cnt_q;

endmodule

// File: rtl/alert_handler_esc_timer.sv
// Per-class escalation engine: interrupt timeout, four timed phases, severity mapping.
module alert_handler_esc_timer
   import alert_handler_pkg::*;
#(
   parameter int AccuCntDw = AccuCntDwDef,
   parameter int EscCntDw  = EscCntDwDef,
   parameter int N_ESC_SEV = NEscSevDef
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           en_i,
   input  logic                           clr_i,
   input  logic                           accu_trig_i,
   input  logic [AccuCntDw-1:0]           accu_thresh_i,
   input  logic [EscCntDw-1:0]            timeout_cyc_i,
   input  logic                           intr_ack_i,
   input  logic [N_PHASES*EscCntDw-1:0]   phase_cyc_i,
   input  logic [N_ESC_SEV-1:0]           esc_en_i,
   input  logic [N_ESC_SEV*PHASE_DW-1:0]  esc_map_i,
   output logic [AccuCntDw-1:0]           accu_cnt_o,
   output logic                           accu_fail_o,
   output logic                           esc_trig_o,
   output logic [EscCntDw-1:0]            esc_cnt_o,
   output logic [2:0]                     esc_state_o,
   output logic [N_ESC_SEV-1:0]           esc_sig_o
);

   cls_state_e          state_q, state_d;
   logic [EscCntDw-1:0] cnt_q, cnt_d, cnt_inc, phase_cyc;
   logic                trig, hit, esc_trig_q, esc_trig_d;
   logic                timeout_end, phase_end;

   assign trig = accu_trig_i & en_i;

   alert_handler_accu #(
      .AccuCntDw(AccuCntDw)
   ) u_accu (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clr_i   (clr_i),
      .trig_i  (trig),
      .thresh_i(accu_thresh_i),
      .cnt_o   (accu_cnt_o),
      .hit_o   (hit),
      .fail_o  (accu_fail_o)
   );

   assign cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + EscCntDw'(1);
   assign phase_cyc   = phase_cyc_i[int'(state_q[1:0])*EscCntDw +: EscCntDw];
   // A zero-length phase still lasts one cycle.
   assign phase_end   = (phase_cyc == '0) || (cnt_q >= phase_cyc - EscCntDw'(1));
   assign timeout_end = cnt_q >= timeout_cyc_i - EscCntDw'(1);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         Idle: begin
            cnt_d = '0;
            if (hit) begin
               state_d = Phase0;
            end else if (trig && (timeout_cyc_i != '0)) begin
               state_d = Timeout;
            end
         end
         Timeout: begin
            if (hit || timeout_end) begin
               state_d = Phase0;
               cnt_d   = '0;
            end else if (intr_ack_i || !en_i) begin
               state_d = Idle;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         Phase0, Phase1, Phase2, Phase3: begin
            if (phase_end) begin
               state_d = (state_q == Phase3) ? Terminal
                                             : cls_state_e'({1'b1, state_q[1:0] + 2'd1});
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         Terminal: cnt_d = '0;
         default: begin
            state_d = Idle;
            cnt_d   = '0;
         end
      endcase
      if (clr_i) begin
         state_d = Idle;
         cnt_d   = '0;
      end
   end

   // Phase0 is only reachable from Idle/Timeout, so this marks its first cycle.
   assign esc_trig_d = (state_d == Phase0) && (state_q != Phase0);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= Idle;
         cnt_q      <= '0;
         esc_trig_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         esc_trig_q <= esc_trig_d;
      end
   end

   for (genvar s = 0; s < N_ESC_SEV; s++) begin : g_sig
      assign esc_sig_o[s] = esc_en_i[s] & state_q[2] &
                            (state_q[1:0] == esc_map_i[s*PHASE_DW +: PHASE_DW]);
   end

   assign esc_trig_o  = esc_trig_q;
   assign esc_cnt_o   = cnt_q;
   assign esc_state_o = state_q;

endmodule

// File: tb/tb_alert_handler_esc_timer.sv
// Scoreboard bench: driver pushes model predictions, negedge monitor pops and compares.
module tb_alert_handler_esc_timer;

   localparam int ADW  = 4;
   localparam int EDW  = 32;
   localparam int NS   = 4;
   localparam int AMAX = (1 << ADW) - 1;
   localparam longint unsigned CMAX = 64'hFFFF_FFFF;

   logic              clk = 1'b0;
   logic              rst_ni = 1'b0, en_i = 1'b0, clr_i = 1'b0, accu_trig_i = 1'b0, intr_ack_i = 1'b0;
   logic [ADW-1:0]    accu_thresh_i = '0;
   logic [EDW-1:0]    timeout_cyc_i = '0;
   logic [4*EDW-1:0]  phase_cyc_i = '0;
   logic [NS-1:0]     esc_en_i = '0;
   logic [2*NS-1:0]   esc_map_i = '0;
   logic [ADW-1:0]    accu_cnt_o;
   logic              accu_fail_o, esc_trig_o;
   logic [EDW-1:0]    esc_cnt_o;
   logic [2:0]        esc_state_o;
   logic [NS-1:0]     esc_sig_o;

   alert_handler_esc_timer #(.AccuCntDw(ADW), .EscCntDw(EDW), .N_ESC_SEV(NS)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .en_i(en_i), .clr_i(clr_i), .accu_trig_i(accu_trig_i),
      .accu_thresh_i(accu_thresh_i), .timeout_cyc_i(timeout_cyc_i), .intr_ack_i(intr_ack_i),
      .phase_cyc_i(phase_cyc_i), .esc_en_i(esc_en_i), .esc_map_i(esc_map_i),
      .accu_cnt_o(accu_cnt_o), .accu_fail_o(accu_fail_o), .esc_trig_o(esc_trig_o),
      .esc_cnt_o(esc_cnt_o), .esc_state_o(esc_state_o), .esc_sig_o(esc_sig_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned      accu_cnt;
      bit               accu_fail;
      bit               esc_trig;
      longint unsigned  esc_cnt;
      int unsigned      state;
      int unsigned      sig;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int errors = 0;

   // Reference model: mode 0 idle, 1 waiting on interrupt, 2 escalating (phase ph), 3 terminal.
   int               m_acc = 0, m_mode = 0, m_ph = 0;
   longint unsigned  m_cnt = 0;
   bit               m_etrig = 0;

   task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic longint unsigned sat_inc(input longint unsigned v);
      return (v >= CMAX) ? CMAX : v + 1;
   endfunction

   // Drive one cycle of inputs, predict what the DUT shows this cycle, then advance the model.
   task automatic cyc(input bit r, input bit e, input bit c, input bit t, input bit a);
      exp_t x;
      bit trig, hit, netrig;
      int nacc, nmode, nph;
      longint unsigned ncnt, tlim, dur;
      rst_ni = r; en_i = e; clr_i = c; accu_trig_i = t; intr_ack_i = a;
      trig = t && e;
      x.accu_cnt  = m_acc;
      x.accu_fail = trig && (m_acc == AMAX);
      x.esc_trig  = m_etrig;
      x.esc_cnt   = m_cnt;
      x.state     = (m_mode == 2) ? 4 + m_ph : m_mode;
      x.sig       = 0;
      for (int s = 0; s < NS; s++)
         if (esc_en_i[s] && m_mode == 2 && int'(esc_map_i[2*s +: 2]) == m_ph) x.sig |= (1 << s);
      q.push_back(x);
      if (!r) begin
         m_acc = 0; m_mode = 0; m_ph = 0; m_cnt = 0; m_etrig = 0;
      end else begin
         hit    = trig && (m_acc >= int'(accu_thresh_i));
         nacc   = c ? 0 : ((trig && m_acc < AMAX) ? m_acc + 1 : m_acc);
         nmode  = m_mode; nph = m_ph; ncnt = m_cnt; netrig = 0;
         tlim   = (timeout_cyc_i == 0) ? CMAX : longint'(timeout_cyc_i) - 1;
         if (c) begin
            nmode = 0; ncnt = 0;
         end else begin
            case (m_mode)
               0: if (hit) begin
                     nmode = 2; nph = 0; ncnt = 0; netrig = 1;
                  end else if (trig && timeout_cyc_i != 0) begin
                     nmode = 1; ncnt = 0;
                  end
               1: if (hit || m_cnt >= tlim) begin
                     nmode = 2; nph = 0; ncnt = 0; netrig = 1;
                  end else if (a || !e) begin
                     nmode = 0; ncnt = 0;
                  end else ncnt = sat_inc(m_cnt);
               2: begin
                  dur = longint'(phase_cyc_i[m_ph*EDW +: EDW]);
                  if (dur == 0) dur = 1;
                  if (m_cnt + 1 >= dur) begin
                     if (m_ph == 3) nmode = 3; else nph = m_ph + 1;
                     ncnt = 0;
                  end else ncnt = sat_inc(m_cnt);
               end
               default: ncnt = 0;
            endcase
         end
         m_acc = nacc; m_mode = nmode; m_ph = nph; m_cnt = ncnt; m_etrig = netrig;
      end
      @(posedge clk); #1;
   endtask

   task automatic set_phases(input int unsigned p0, input int unsigned p1,
                             input int unsigned p2, input int unsigned p3);
      phase_cyc_i = {p3[EDW-1:0], p2[EDW-1:0], p1[EDW-1:0], p0[EDW-1:0]};
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1, 1, 0, 0, 0);
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t x;
         x = q.pop_front();
         chk("accu_cnt",  accu_cnt_o,  x.accu_cnt);
         chk("accu_fail", accu_fail_o, x.accu_fail);
         chk("esc_trig",  esc_trig_o,  x.esc_trig);
         chk("esc_cnt",   esc_cnt_o,   x.esc_cnt);
         chk("esc_state", esc_state_o, x.state);
         chk("esc_sig",   esc_sig_o,   x.sig);
      end
   end

   initial begin
      esc_en_i = '1;
      esc_map_i = {2'd3, 2'd2, 2'd1, 2'd0};
      set_phases(1, 2, 3, 4);
      @(posedge clk); @(posedge clk); #1;
      cyc(0, 0, 0, 0, 0);
      // accumulate to threshold 2, third alert escalates
      accu_thresh_i = 2; timeout_cyc_i = 0;
      idle(1);
      for (int i = 0; i < 3; i++) cyc(1, 1, 0, 1, 0);
      idle(4);
      // interrupt timeout runs out, then a retry aborted by ack
      cyc(1, 1, 1, 0, 0);
      accu_thresh_i = 15; timeout_cyc_i = 5;
      cyc(1, 1, 0, 1, 0);
      idle(8);
      cyc(1, 1, 1, 0, 0);
      cyc(1, 1, 0, 1, 0);
      idle(3);
      cyc(1, 1, 0, 0, 1);
      idle(3);
      // full phase walk into Terminal
      cyc(1, 1, 1, 0, 0);
      accu_thresh_i = 0; timeout_cyc_i = 0;
      cyc(1, 1, 0, 1, 0);
      idle(14);
      // clear during Phase2, then clear with a simultaneous alert
      cyc(1, 1, 1, 0, 0);
      set_phases(3, 3, 10, 10);
      cyc(1, 1, 0, 1, 0);
      idle(8);
      cyc(1, 1, 1, 0, 0);
      cyc(1, 1, 1, 1, 0);
      idle(2);
      // saturation of the accumulator
      accu_thresh_i = 15; set_phases(1, 1, 1, 1);
      for (int i = 0; i < 18; i++) cyc(1, 1, 0, 1, 0);
      idle(6);
      // disabled class ignores alerts, then reset mid-Phase1
      cyc(1, 1, 1, 0, 0);
      for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, 0);
      accu_thresh_i = 0; set_phases(2, 6, 2, 2);
      cyc(1, 1, 0, 1, 0);
      idle(3);
      cyc(0, 1, 0, 0, 0);
      idle(2);
      // randomized traffic with periodic reconfiguration
      for (int i = 0; i < 4000; i++) begin
         if (i % 150 == 0) begin
            accu_thresh_i = ADW'($urandom_range(0, 6));
            timeout_cyc_i = EDW'($urandom_range(0, 8));
            set_phases($urandom_range(0, 5), $urandom_range(0, 5),
                       $urandom_range(0, 5), $urandom_range(0, 5));
            esc_en_i  = NS'($urandom);
            esc_map_i = (2*NS)'($urandom);
         end
         cyc($urandom_range(0, 99) != 0, $urandom_range(0, 9) != 0,
             $urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 19) == 0);
      end
      @(negedge clk); #1;
      chk("queue_drained", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
